// File: rtl/jzjpcc_load_processor.sv
// Memory-stage load unit: drives the RAM word address, carries load control across the
// one-cycle RAM latency, and extracts/extends the result. JZJPCC_MISALIGNED_LOAD_EN enables split loads.
module jzjpcc_load_processor (
   input  logic        clock,
   input  logic        reset,
   input  logic        loadValid_execute,
   input  logic [2:0]  funct3_execute,
   input  logic [31:0] aluResult_execute,
   input  logic        stall,
   input  logic        flush,
   output logic [29:0] memAddress_execute,
   input  logic [31:0] memReadData_memory,
   output logic        loadStallRequest,
   output logic        loadValid_memory,
   output logic [31:0] loadResult_memory,
   output logic        misaligned_memory
);

   // True when the access runs past the end of its 32-bit word.
   function automatic logic crosses(input logic [2:0] f3, input logic [1:0] o);
      case (f3)
         3'b001, 3'b101: crosses = (o == 2'd3);
         3'b010:         crosses = (o != 2'd0);
         default:        crosses = 1'b0;
      endcase
   endfunction

   logic        mem_valid;
   logic [2:0]  mem_funct3;
   logic [1:0]  mem_offset;
   logic        hold_active;
   logic [31:0] hold_buf;
   logic        bubble;
   logic [31:0] src;
   logic [31:0] shifted;
   logic [31:0] extracted;

`ifdef JZJPCC_MISALIGNED_LOAD_EN
   typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_t;
   state_t      state;
   state_t      state_next;
   logic        split_enter;
   logic        split_first;
   logic [29:0] split_addr;
   logic [31:0] low_buf;
   logic        mem_split;
   logic [63:0] wide;

   assign split_enter = (state == IDLE) & loadValid_execute & ~stall & ~flush &
                        crosses(funct3_execute, aluResult_execute[1:0]);
   assign bubble = flush | split_enter;

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (split_enter) state_next = SPLIT;
         SPLIT:   state_next = stall ? SPLIT : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      loadStallRequest   = split_enter;
      memAddress_execute = (state == SPLIT) ? split_addr + 30'd1 : aluResult_execute[31:2];
   end

   // low_buf takes word A in the first SPLIT cycle only, when the RAM returns it.
   always_ff @(posedge clock) begin
      if (reset) begin
         split_addr  <= 30'd0;
         split_first <= 1'b0;
         low_buf     <= 32'h0;
         mem_split   <= 1'b0;
      end else begin
         if (split_enter) split_addr <= aluResult_execute[31:2];
         split_first <= split_enter;
         if (split_first) low_buf <= memReadData_memory;
         if (!stall) mem_split <= (state == SPLIT);
      end
   end

   assign misaligned_memory = 1'b0;
`else
   assign bubble             = flush;
   assign loadStallRequest   = 1'b0;
   assign memAddress_execute = aluResult_execute[31:2];
   assign misaligned_memory  = mem_valid & crosses(mem_funct3, mem_offset);
`endif

   // loadValid_memory qualifies loadResult_memory for every cycle the memory-stage register
   // holds a load; there is no ready, back-pressure arrives only through stall.
   always_ff @(posedge clock) begin
      if (reset) begin
         mem_valid  <= 1'b0;
         mem_funct3 <= 3'd0;
         mem_offset <= 2'd0;
      end else if (!stall) begin
         mem_valid  <= loadValid_execute & ~bubble;
         mem_funct3 <= funct3_execute;
         mem_offset <= aluResult_execute[1:0];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         hold_active <= 1'b0;
         hold_buf    <= 32'h0;
      end else if (stall) begin
         if (mem_valid && !hold_active) begin
            hold_active <= 1'b1;
            hold_buf    <= memReadData_memory;
         end
      end else begin
         hold_active <= 1'b0;
      end
   end

   always_comb begin
      src = hold_active ? hold_buf : memReadData_memory;
`ifdef JZJPCC_MISALIGNED_LOAD_EN
      wide    = mem_split ? {src, low_buf} : {32'h0, src};
      shifted = 32'(wide >> {mem_offset, 3'b000});
`else
      shifted = src >> {mem_offset, 3'b000};
`endif
      case (mem_funct3)
         3'b000:  extracted = {{24{shifted[7]}}, shifted[7:0]};
         3'b100:  extracted = {24'h0, shifted[7:0]};
         3'b001:  extracted = {{16{shifted[15]}}, shifted[15:0]};
         3'b101:  extracted = {16'h0, shifted[15:0]};
         3'b010:  extracted = shifted;
         default: extracted = 32'h0;
      endcase
      loadValid_memory  = mem_valid;
      loadResult_memory = 32'h0;
      if (mem_valid && !misaligned_memory) loadResult_memory = extracted;
   end

endmodule

// File: tb/tb_jzjpcc_load_processor.sv
// Directed bench for jzjpcc_load_processor: a byte-addressed RAM model predicts every memory-stage
// output cycle; split-load checks apply when JZJPCC_MISALIGNED_LOAD_EN is defined.
module tb_jzjpcc_load_processor;
   logic        clock = 1'b0;
   logic        reset;
   logic        loadValid_execute;
   logic [2:0]  funct3_execute;
   logic [31:0] aluResult_execute;
   logic        stall;
   logic        flush;
   logic [29:0] memAddress_execute;
   logic [31:0] memReadData_memory;
   logic        loadStallRequest;
   logic        loadValid_memory;
   logic [31:0] loadResult_memory;
   logic        misaligned_memory;

   jzjpcc_load_processor dut (
      .clock              (clock),
      .reset              (reset),
      .loadValid_execute  (loadValid_execute),
      .funct3_execute     (funct3_execute),
      .aluResult_execute  (aluResult_execute),
      .stall              (stall),
      .flush              (flush),
      .memAddress_execute (memAddress_execute),
      .memReadData_memory (memReadData_memory),
      .loadStallRequest   (loadStallRequest),
      .loadValid_memory   (loadValid_memory),
      .loadResult_memory  (loadResult_memory),
      .misaligned_memory  (misaligned_memory)
   );

   // ---------------- clock / reset / RAM ----------------
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   logic [31:0] ram [0:63];
   logic [31:0] rd_q = 32'h0;
   logic        corrupt = 1'b0;
   logic [31:0] junk = 32'h0;
   always @(posedge clock) rd_q <= ram[memAddress_execute[5:0]];
   assign memReadData_memory = corrupt ? junk : rd_q;

   // ---------------- model ----------------
   function automatic int load_size(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         3'b010:         return 4;
         default:        return 0;
      endcase
   endfunction

   function automatic bit crosses_model(input logic [2:0] f3, input logic [31:0] a);
      int size;
      size = load_size(f3);
      return (size != 0) && ((int'(a[1:0]) + size) > 4);
   endfunction

   function automatic logic [7:0] ram_byte(input logic [31:0] a);
      logic [31:0] w;
      w = ram[a[7:2]];
      return w[8*a[1:0] +: 8];
   endfunction

   // {valid, misaligned, result}
   function automatic logic [33:0] model_load(input logic [2:0] f3, input logic [31:0] a);
      int size;
      logic [31:0] val;
      size = load_size(f3);
      if (size == 0) return {2'b10, 32'h0};
`ifndef JZJPCC_MISALIGNED_LOAD_EN
      if (crosses_model(f3, a)) return {2'b11, 32'h0};
`endif
      val = 32'h0;
      for (int i = 0; i < size; i++) val = val | (32'(ram_byte(a + 32'(i))) << (8 * i));
      if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~((32'h1 << (8 * size)) - 32'h1);
      return {2'b10, val};
   endfunction

   // ---------------- scoreboard ----------------
   logic [33:0] exp_q[$];
   int          due_q[$];
   int          vectors = 0;
   int          errors = 0;
   bit          chk_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      vectors++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp_v);
      end
   endtask

   always @(negedge clock) begin : compare_proc
      logic [33:0] exp_v;
      if (chk_en) begin
         exp_v = 34'h0;
         if (due_q.size() > 0 && due_q[0] == cyc) begin
            exp_v = exp_q.pop_front();
            void'(due_q.pop_front());
         end
         check("mem_stage{valid,mis,result}",
               64'({loadValid_memory, misaligned_memory, loadResult_memory}), 64'(exp_v));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic v, input logic [2:0] f3, input logic [31:0] a,
                        input logic st, input logic fl, input logic c);
      @(posedge clock);
      #1;
      loadValid_execute = v;
      funct3_execute    = f3;
      aluResult_execute = a;
      stall             = st;
      flush             = fl;
      corrupt           = c;
      junk              = $urandom;
   endtask

   task automatic idle();
      drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0);
      #2;
      check("idle_stall_req", 64'(loadStallRequest), 64'(1'b0));
   endtask

   task automatic load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] hand);
      logic [33:0] m;
      int n;
      m = model_load(f3, a);
      check("model_pin", 64'(m[31:0]), 64'(hand));
      drive(1'b1, f3, a, 1'b0, 1'b0, 1'b0);
      n = cyc;
      #2;
`ifdef JZJPCC_MISALIGNED_LOAD_EN
      if (crosses_model(f3, a)) begin
         check("split_req_first", 64'(loadStallRequest), 64'(1'b1));
         check("split_addr_first", 64'(memAddress_execute), 64'(a[31:2]));
         due_q.push_back(n + 2);
         exp_q.push_back(m);
         drive(1'b1, f3, a, 1'b0, 1'b0, 1'b0);
         #2;
         check("split_req_second", 64'(loadStallRequest), 64'(1'b0));
         check("split_addr_second", 64'(memAddress_execute), 64'(a[31:2] + 30'd1));
         return;
      end
`endif
      check("load_req", 64'(loadStallRequest), 64'(1'b0));
      check("load_addr", 64'(memAddress_execute), 64'(a[31:2]));
      due_q.push_back(n + 1);
      exp_q.push_back(m);
   endtask

   // ---------------- directed sequence ----------------
   initial begin : main
      logic [33:0] m;
      int n;
      for (int i = 0; i < 64; i++) ram[i] = 32'h0;
      ram[0] = 32'h8081_7F01;
      ram[1] = 32'h1234_5678;
      reset = 1'b1;
      loadValid_execute = 1'b0;
      funct3_execute = 3'b000;
      aluResult_execute = 32'h0;
      stall = 1'b0;
      flush = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk_en = 1'b1;
      reset = 1'b0;
      #2;
      check("reset_stall_req", 64'(loadStallRequest), 64'(1'b0));

      // byte / halfword / word extraction, back to back
      load(3'b000, 32'h103, 32'hFFFF_FF80);
      load(3'b100, 32'h103, 32'h0000_0080);
      load(3'b000, 32'h100, 32'h0000_0001);
      load(3'b000, 32'h101, 32'h0000_007F);
      idle();
      load(3'b001, 32'h102, 32'hFFFF_8081);
      load(3'b101, 32'h102, 32'h0000_8081);
      load(3'b001, 32'h100, 32'h0000_7F01);
      load(3'b001, 32'h101, 32'hFFFF_817F);
      load(3'b010, 32'h100, 32'h8081_7F01);
      load(3'b011, 32'h100, 32'h0000_0000);
      load(3'b010, 32'h104, 32'h1234_5678);
      idle();

      // stall hold: RAM data is garbage in the 2nd and 3rd stall cycles
      load(3'b010, 32'h100, 32'h8081_7F01);
      n = cyc;
      m = model_load(3'b010, 32'h100);
      for (int k = 2; k <= 4; k++) begin
         due_q.push_back(n + k);
         exp_q.push_back(m);
      end
      drive(1'b0, 3'b010, 32'h100, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 3'b010, 32'h100, 1'b1, 1'b0, 1'b1);
      drive(1'b0, 3'b010, 32'h100, 1'b1, 1'b0, 1'b1);
      load(3'b100, 32'h103, 32'h0000_0080);
      idle();

      // stall and flush together: stall wins, the load stays visible
      load(3'b000, 32'h103, 32'hFFFF_FF80);
      n = cyc;
      due_q.push_back(n + 2);
      exp_q.push_back(model_load(3'b000, 32'h103));
      drive(1'b0, 3'b000, 32'h100, 1'b1, 1'b1, 1'b0);
      idle();
      // plain flush turns the next slot into a bubble
      drive(1'b1, 3'b010, 32'h100, 1'b0, 1'b1, 1'b0);
      idle();
      idle();

      ram[0] = 32'hDDCC_BBAA;
      ram[1] = 32'h4433_2211;
`ifdef JZJPCC_MISALIGNED_LOAD_EN
      load(3'b010, 32'h102, 32'h2211_DDCC);
      load(3'b001, 32'h103, 32'h0000_11DD);
      load(3'b101, 32'h103, 32'h0000_11DD);
      load(3'b010, 32'h101, 32'h11DD_CCBB);
      load(3'b000, 32'h103, 32'hFFFF_FFDD);
      idle();

      // flush in SPLIT: no result, FSM back to IDLE (aligned address, no request)
      drive(1'b1, 3'b010, 32'h102, 1'b0, 1'b0, 1'b0);
      #2;
      check("flush_split_req", 64'(loadStallRequest), 64'(1'b1));
      drive(1'b1, 3'b010, 32'h102, 1'b0, 1'b1, 1'b0);
      load(3'b010, 32'h100, 32'hDDCC_BBAA);
      idle();

      // reset in SPLIT discards the split
      drive(1'b1, 3'b010, 32'h102, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 3'b010, 32'h102, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      idle();
      reset = 1'b0;
      load(3'b010, 32'h104, 32'h4433_2211);
      idle();
`else
      load(3'b010, 32'h101, 32'h0000_0000);
      load(3'b001, 32'h103, 32'h0000_0000);
      load(3'b101, 32'h102, 32'h0000_DDCC);
      load(3'b001, 32'h102, 32'hFFFF_DDCC);
      load(3'b010, 32'h103, 32'h0000_0000);
      load(3'b100, 32'h103, 32'h0000_00DD);
      idle();
`endif

      // reset with a valid load in the memory stage
      load(3'b010, 32'h104, 32'h4433_2211);
      drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      idle();
      reset = 1'b0;
      idle();
      idle();

      check("pending_expectations", 64'(due_q.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
